// File: rtl/rv32_pc_redirect_ctrl.sv
// PC overwrite sequencer: arbitrates trap/MRET/branch redirects, checks branch
// target alignment, holds a redirect across stalls and stretches the front-end flush.
module rv32_pc_redirect_ctrl #(
    parameter int unsigned C_EXT        = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        trap_valid,
    input  logic [31:0] mtvec,
    input  logic        mret_valid,
    input  logic [31:0] mepc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        pc_overwrite_enable,
    output logic [31:0] pc_overwrite_data,
    output logic        flush,
    output logic        busy,
    output logic        misaligned_valid,
    output logic [31:0] misaligned_addr
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } state_e;

    localparam logic [3:0] RELOAD   = 4'(FLUSH_CYCLES - 1);
    localparam logic       MULTI    = (FLUSH_CYCLES > 1);

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [3:0]  count_q, count_d;
    logic        mis_q, mis_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    logic [31:0] trap_tgt;
    logic [31:0] mret_tgt;
    logic        br_mis;
    logic        req;
    logic        sel_mis;
    logic [31:0] sel_tgt;
    logic        start;
    logic [31:0] hold_tgt;
    logic        hold_mis;

    logic        en_c;
    logic [31:0] data_c;
    logic        flush_c;
    logic        mv_c;
    logic [31:0] ma_c;

    logic        unused_bits;
    assign unused_bits = ^{mtvec[1:0], mepc[0]};

    always_comb begin
        trap_tgt = {mtvec[31:2], 2'b00};
        if (C_EXT != 0) begin
            mret_tgt = {mepc[31:1], 1'b0};
            br_mis   = br_target[0];
        end else begin
            mret_tgt = {mepc[31:2], 2'b00};
            br_mis   = |br_target[1:0];
        end
        req     = trap_valid | mret_valid | br_valid;
        sel_mis = !trap_valid && !mret_valid && br_valid && br_mis;
        if (trap_valid)      sel_tgt = trap_tgt;
        else if (mret_valid) sel_tgt = mret_tgt;
        else if (br_mis)     sel_tgt = trap_tgt;
        else                 sel_tgt = br_target;
        // A trap during HOLD supersedes both the held target and any misaligned report.
        hold_tgt = trap_valid ? trap_tgt : pending_q;
        hold_mis = mis_q && !trap_valid;
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        count_d    = count_q;
        mis_d      = mis_q;
        mis_addr_d = mis_addr_q;
        en_c       = 1'b0;
        data_c     = '0;
        flush_c    = 1'b0;
        mv_c       = 1'b0;
        ma_c       = '0;
        start      = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = req;
            end
            HOLD: begin
                en_c    = 1'b1;
                data_c  = hold_tgt;
                flush_c = 1'b1;
                if (stall_in) begin
                    pending_d = hold_tgt;
                    mis_d     = hold_mis;
                end else begin
                    mv_c      = hold_mis;
                    ma_c      = hold_mis ? mis_addr_q : '0;
                    pending_d = '0;
                    mis_d     = 1'b0;
                    count_d   = RELOAD;
                    state_d   = MULTI ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                start   = trap_valid;
                if (!trap_valid && !stall_in) begin
                    count_d = count_q - 4'd1;
                    if (count_q <= 4'd1) begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New redirect accepted from IDLE, or a trap restarting an in-progress flush.
        if (start) begin
            en_c    = 1'b1;
            data_c  = sel_tgt;
            flush_c = 1'b1;
            if (stall_in) begin
                state_d    = HOLD;
                pending_d  = sel_tgt;
                mis_d      = sel_mis;
                mis_addr_d = br_target;
            end else begin
                mv_c    = sel_mis;
                ma_c    = sel_mis ? br_target : '0;
                count_d = RELOAD;
                state_d = MULTI ? FLUSH : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            count_q    <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the request inputs.
    assign pc_overwrite_enable = reset_n & en_c;
    assign pc_overwrite_data   = reset_n ? data_c : '0;
    assign flush               = reset_n & flush_c;
    assign busy                = reset_n & (state_q != IDLE);
    assign misaligned_valid    = reset_n & mv_c;
    assign misaligned_addr     = reset_n ? ma_c : '0;

endmodule

// File: tb/tb_rv32_pc_redirect_ctrl.sv
// Scoreboard bench: two controllers (C_EXT=0 and C_EXT=1) share stimulus; the
// driver queues hand-computed expectations, the monitor checks them mid-cycle.
module tb_rv32_pc_redirect_ctrl;

    logic        clk;
    logic        reset_n;
    logic        stall_in;
    logic        trap_valid;
    logic [31:0] mtvec;
    logic        mret_valid;
    logic [31:0] mepc;
    logic        br_valid;
    logic [31:0] br_target;

    logic        a_en, a_fl, a_bz, a_mv;
    logic [31:0] a_data, a_ma;
    logic        b_en, b_fl, b_bz, b_mv;
    logic [31:0] b_data, b_ma;

    rv32_pc_redirect_ctrl #(.C_EXT(0), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
        .trap_valid(trap_valid), .mtvec(mtvec),
        .mret_valid(mret_valid), .mepc(mepc),
        .br_valid(br_valid), .br_target(br_target),
        .pc_overwrite_enable(a_en), .pc_overwrite_data(a_data),
        .flush(a_fl), .busy(a_bz),
        .misaligned_valid(a_mv), .misaligned_addr(a_ma)
    );

    rv32_pc_redirect_ctrl #(.C_EXT(1), .FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
        .trap_valid(trap_valid), .mtvec(mtvec),
        .mret_valid(mret_valid), .mepc(mepc),
        .br_valid(br_valid), .br_target(br_target),
        .pc_overwrite_enable(b_en), .pc_overwrite_data(b_data),
        .flush(b_fl), .busy(b_bz),
        .misaligned_valid(b_mv), .misaligned_addr(b_ma)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        en;
        logic [31:0] data;
        logic        fl;
        logic        bz;
        logic        mv;
        logic [31:0] ma;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk({e.name, "/a"}, "enable", {31'd0, a_en}, {31'd0, e.en});
                chk({e.name, "/a"}, "data",   a_data,        e.data);
                chk({e.name, "/a"}, "flush",  {31'd0, a_fl}, {31'd0, e.fl});
                chk({e.name, "/a"}, "busy",   {31'd0, a_bz}, {31'd0, e.bz});
                chk({e.name, "/a"}, "mis_v",  {31'd0, a_mv}, {31'd0, e.mv});
                chk({e.name, "/a"}, "mis_a",  a_ma,          e.ma);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk({e.name, "/b"}, "enable", {31'd0, b_en}, {31'd0, e.en});
                chk({e.name, "/b"}, "data",   b_data,        e.data);
                chk({e.name, "/b"}, "flush",  {31'd0, b_fl}, {31'd0, e.fl});
                chk({e.name, "/b"}, "busy",   {31'd0, b_bz}, {31'd0, e.bz});
                chk({e.name, "/b"}, "mis_v",  {31'd0, b_mv}, {31'd0, e.mv});
                chk({e.name, "/b"}, "mis_a",  b_ma,          e.ma);
            end
        end
    end

    task automatic drive(input logic tr, input logic mr, input logic br, input logic st,
                         input logic [31:0] mtv, input logic [31:0] mep, input logic [31:0] brt);
        trap_valid = tr;
        mret_valid = mr;
        br_valid   = br;
        stall_in   = st;
        mtvec      = mtv;
        mepc       = mep;
        br_target  = brt;
    endtask

    // Expectations for C_EXT=0 (a) and C_EXT=1 (b), which differ only in alignment.
    task automatic exp2(input string nm, input logic en, input logic fl, input logic bz,
                        input logic [31:0] da, input logic mva, input logic [31:0] maa,
                        input logic [31:0] db, input logic mvb, input logic [31:0] mab);
        exp_t e;
        e.name = nm; e.en = en; e.fl = fl; e.bz = bz;
        e.data = da; e.mv = mva; e.ma = maa;
        q_a.push_back(e);
        e.data = db; e.mv = mvb; e.ma = mab;
        q_b.push_back(e);
    endtask

    task automatic exp_both(input string nm, input logic en, input logic [31:0] d,
                            input logic fl, input logic bz);
        exp2(nm, en, fl, bz, d, 1'b0, 32'h0, d, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input string nm, input logic fl, input logic bz);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        exp_both(nm, 1'b0, 32'h0, fl, bz);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        exp_both("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        idle_step("post_reset", 1'b0, 1'b0);

        // Branch, no stall: two flush cycles, one busy cycle
        drive(0, 0, 1, 0, 32'h0, 32'h0, 32'h100);
        exp_both("br_accept", 1'b1, 32'h100, 1'b1, 1'b0);
        tick();
        idle_step("br_flush", 1'b1, 1'b1);
        idle_step("br_idle", 1'b0, 1'b0);

        // Simultaneous requests: trap wins, mtvec low bits dropped
        drive(1, 1, 1, 0, 32'h203, 32'h300, 32'h100);
        exp_both("prio", 1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        idle_step("prio_flush", 1'b1, 1'b1);
        idle_step("prio_idle", 1'b0, 1'b0);

        // Stalled branch held for three cycles, released on the fourth
        drive(0, 0, 1, 1, 32'h0, 32'h0, 32'h80);
        exp_both("hold_req", 1'b1, 32'h80, 1'b1, 1'b0);
        tick();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        exp_both("hold_1", 1'b1, 32'h80, 1'b1, 1'b1);
        tick();
        exp_both("hold_2", 1'b1, 32'h80, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        exp_both("hold_rel", 1'b1, 32'h80, 1'b1, 1'b1);
        tick();
        idle_step("hold_flush", 1'b1, 1'b1);
        idle_step("hold_idle", 1'b0, 1'b0);

        // Trap replaces held target; later mret/branch ignored; stalled flush holds count
        drive(0, 0, 1, 1, 32'h0, 32'h0, 32'h80);
        exp_both("trap_hold_req", 1'b1, 32'h80, 1'b1, 1'b0);
        tick();
        drive(1, 0, 0, 1, 32'h400, 32'h0, 32'h0);
        exp_both("trap_in_hold", 1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        drive(0, 0, 1, 1, 32'h0, 32'h0, 32'h500);
        exp_both("hold_br_ign", 1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        drive(0, 1, 0, 1, 32'h0, 32'h600, 32'h0);
        exp_both("hold_mret_ign", 1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        exp_both("trap_hold_rel", 1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        exp_both("flush_stalled", 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        idle_step("flush_last", 1'b1, 1'b1);
        idle_step("trap_hold_idle", 1'b0, 1'b0);

        // Trap during FLUSH restarts; branch during FLUSH ignored
        drive(0, 0, 1, 0, 32'h0, 32'h0, 32'h100);
        exp_both("rs_accept", 1'b1, 32'h100, 1'b1, 1'b0);
        tick();
        drive(1, 0, 0, 0, 32'h704, 32'h0, 32'h0);
        exp_both("rs_trap", 1'b1, 32'h704, 1'b1, 1'b1);
        tick();
        drive(0, 0, 1, 0, 32'h0, 32'h0, 32'h900);
        exp_both("rs_br_ign", 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        idle_step("rs_idle", 1'b0, 1'b0);

        // Misaligned only under 4-byte alignment
        drive(0, 0, 1, 0, 32'h200, 32'h0, 32'h102);
        exp2("mis4", 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 32'h102, 32'h102, 1'b0, 32'h0);
        tick();
        idle_step("mis4_flush", 1'b1, 1'b1);
        idle_step("mis4_idle", 1'b0, 1'b0);

        // Odd target misaligned in both; stalled, pulse waits for release
        drive(0, 0, 1, 1, 32'h200, 32'h0, 32'h101);
        exp_both("mis_hold_req", 1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        exp2("mis_hold_rel", 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h101, 32'h200, 1'b1, 32'h101);
        tick();
        idle_step("mis_hold_flush", 1'b1, 1'b1);
        idle_step("mis_hold_idle", 1'b0, 1'b0);

        // MRET return address masking per alignment
        drive(0, 1, 0, 0, 32'h0, 32'h303, 32'h0);
        exp2("mret_mask", 1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 32'h302, 1'b0, 32'h0);
        tick();
        idle_step("mret_flush", 1'b1, 1'b1);
        idle_step("mret_idle", 1'b0, 1'b0);

        // Asynchronous reset while holding a redirect
        drive(0, 0, 1, 1, 32'h0, 32'h0, 32'h80);
        exp_both("rst_hold_req", 1'b1, 32'h80, 1'b1, 1'b0);
        tick();
        exp_both("rst_hold", 1'b1, 32'h80, 1'b1, 1'b1);
        tick();
        reset_n = 1'b0;
        exp_both("rst_async", 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        idle_step("rst_release", 1'b0, 1'b0);
        idle_step("rst_idle", 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
